// File: rtl/count_ctrl.sv
// ---------------------------------------------------------------------------
// count_ctrl -- start/stop/pause controlled up-counter with terminal detect
//
// A run begins when start is seen in IDLE. On that edge the terminal count
// (limit) and the run mode (auto_reload) are captured. The count then climbs
// from 0 to the captured limit. At the limit the block either finishes
// (one-shot: RUN -> DONE -> IDLE) or wraps to 0 and keeps going (periodic).
// Every wrap is counted in reloads, which saturates at 15.
//
// Ports
//   clk          rising-edge clock
//   res          synchronous reset, active low
//   start        begin a run (only honoured in IDLE)
//   stop         abort the current run (RUN/HOLD -> IDLE)
//   pause        level; holds the count while high
//   limit        terminal count, captured on the accepted start
//   auto_reload  run mode, captured on the accepted start (1 = periodic)
//   cnt          current count (registered)
//   busy         high in RUN or HOLD
//   done         one-cycle terminal-count pulse (registered)
//   reloads      wraps in the current run, saturating at 15
//   state        FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11
// ---------------------------------------------------------------------------
module count_ctrl #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] limit,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic [3:0]       reloads,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HOLD = 2'b10,
      S_DONE = 2'b11
   } state_t;

   // registered state
   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic             r_done;
   logic [3:0]       r_reloads;
   logic [WIDTH-1:0] r_lim_q;
   logic             r_auto_q;

   // next-state values
   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_done_nxt;
   logic [3:0]       w_reloads_nxt;
   logic [WIDTH-1:0] w_lim_nxt;
   logic             w_auto_nxt;

   // terminal compare against the captured limit; equality is checked before
   // incrementing, so an all-ones limit never overflows cnt
   logic             w_at_lim;
   logic [3:0]       w_reloads_sat;

   assign w_at_lim      = (r_cnt == r_lim_q);
   assign w_reloads_sat = (r_reloads == 4'hF) ? r_reloads : r_reloads + 4'd1;

   // ------------------------------------------------------------------------
   // state and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!res) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_reloads <= 4'd0;
         r_lim_q   <= '0;
         r_auto_q  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_done    <= w_done_nxt;
         r_reloads <= w_reloads_nxt;
         r_lim_q   <= w_lim_nxt;
         r_auto_q  <= w_auto_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // next-state / datapath logic
   // Within RUN and HOLD the priority is stop, then pause, then counting.
   // done defaults low so it can only ever be a single-cycle pulse.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_done_nxt    = 1'b0;
      w_reloads_nxt = r_reloads;
      w_lim_nxt     = r_lim_q;
      w_auto_nxt    = r_auto_q;

      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_lim_nxt     = limit;
               w_auto_nxt    = auto_reload;
               w_cnt_nxt     = '0;
               w_reloads_nxt = 4'd0;
               w_state_nxt   = S_RUN;
            end
         end

         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (pause) begin
               w_state_nxt = S_HOLD;
            end else if (!w_at_lim) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end else if (r_auto_q) begin
               // periodic: wrap and stay in RUN
               w_cnt_nxt     = '0;
               w_done_nxt    = 1'b1;
               w_reloads_nxt = w_reloads_sat;
            end else begin
               // one-shot: cnt parks at the limit
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end

         S_HOLD: begin
            // the resume edge only changes state; counting restarts next edge
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (!pause) begin
               w_state_nxt = S_RUN;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // outputs
   // ------------------------------------------------------------------------
   assign cnt     = r_cnt;
   assign done    = r_done;
   assign reloads = r_reloads;
   assign state   = r_state;
   assign busy    = (r_state == S_RUN) || (r_state == S_HOLD);

endmodule

// File: tb/tb_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_ctrl -- self-checking bench for count_ctrl (WIDTH=3)
//
// Stimulus records carry their expected post-edge outputs. Each record is
// driven on the falling edge, its expectation queued, and after the rising
// edge the oldest expectation is popped and compared with the DUT.
// ---------------------------------------------------------------------------
module tb_count_ctrl;

   localparam int W = 3;

   typedef struct {
      logic         res;
      logic         start;
      logic         stop;
      logic         pause;
      logic [W-1:0] lim;
      logic         ar;
      logic [W-1:0] e_cnt;
      logic [1:0]   e_st;
      logic         e_done;
      logic [3:0]   e_rel;
      logic         chk_rel;
   } vec_t;

   logic         clk;
   logic         res;
   logic         start;
   logic         stop;
   logic         pause;
   logic [W-1:0] limit;
   logic         auto_reload;
   logic [W-1:0] cnt;
   logic         busy;
   logic         done;
   logic [3:0]   reloads;
   logic [1:0]   state;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_chk;
   int   n_err;

   count_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .res         (res),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .limit       (limit),
      .auto_reload (auto_reload),
      .cnt         (cnt),
      .busy        (busy),
      .done        (done),
      .reloads     (reloads),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(logic r, logic s, logic sp, logic pa, logic [W-1:0] l,
                               logic a, logic [W-1:0] ec, logic [1:0] es, logic ed,
                               logic [3:0] er, logic cr);
      vec_t v;
      v.res = r; v.start = s; v.stop = sp; v.pause = pa; v.lim = l; v.ar = a;
      v.e_cnt = ec; v.e_st = es; v.e_done = ed; v.e_rel = er; v.chk_rel = cr;
      return v;
   endfunction

   task automatic chk(string name, int idx, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v, int idx);
      vec_t e;
      @(negedge clk);
      res = v.res; start = v.start; stop = v.stop; pause = v.pause;
      limit = v.lim; auto_reload = v.ar;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("cnt",   idx, int'(cnt),   int'(e.e_cnt));
      chk("state", idx, int'(state), int'(e.e_st));
      chk("done",  idx, int'(done),  int'(e.e_done));
      chk("busy",  idx, int'(busy),  int'(e.e_st == 2'b01 || e.e_st == 2'b10));
      if (e.chk_rel) chk("reloads", idx, int'(reloads), int'(e.e_rel));
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      res = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      limit = '0; auto_reload = 1'b0;

      //             res st sp pa lim ar | cnt st    dn rel chk
      // reset state
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1));
      // one-shot limit 5
      vecs.push_back(mk(1, 1, 0, 0, 5, 0,  0, 2'b01, 0, 0, 1));
      for (int k = 1; k <= 5; k++)
         vecs.push_back(mk(1, 0, 0, 0, 0, 0,  3'(k), 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  5, 2'b11, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  5, 2'b00, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  5, 2'b00, 0, 0, 1));
      // pause at 3 for two cycles, resume, stop at 6
      vecs.push_back(mk(1, 1, 0, 0, 7, 0,  0, 2'b01, 0, 0, 1));
      for (int k = 1; k <= 3; k++)
         vecs.push_back(mk(1, 0, 0, 0, 0, 0,  3'(k), 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,  3, 2'b10, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,  3, 2'b10, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  3, 2'b01, 0, 0, 1));
      for (int k = 4; k <= 6; k++)
         vecs.push_back(mk(1, 0, 0, 0, 0, 0,  3'(k), 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,  6, 2'b00, 0, 0, 1));
      // limit 0: done on first RUN edge
      vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 2'b11, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1));
      // limit 7 (all ones), start with limit 2 mid-run is ignored
      vecs.push_back(mk(1, 1, 0, 0, 7, 0,  0, 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 2, 1,  2, 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 2, 1,  3, 2'b01, 0, 0, 1));
      for (int k = 4; k <= 7; k++)
         vecs.push_back(mk(1, 0, 0, 0, 0, 0,  3'(k), 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  7, 2'b11, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  7, 2'b00, 0, 0, 1));
      // stop from HOLD beats pause
      vecs.push_back(mk(1, 1, 0, 0, 3, 0,  0, 2'b01, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 2'b10, 0, 0, 1));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,  0, 2'b00, 0, 0, 1));
      // reset mid-run at cnt 4, start while in reset ignored
      vecs.push_back(mk(1, 1, 0, 0, 7, 1,  0, 2'b01, 0, 0, 1));
      for (int k = 1; k <= 4; k++)
         vecs.push_back(mk(1, 0, 0, 0, 0, 0,  3'(k), 2'b01, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 0, 5, 0,  0, 2'b00, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 5, 0,  0, 2'b00, 0, 0, 1));

      foreach (vecs[i]) apply(vecs[i], i);

      // auto-reload limit 2: wraps every third edge, reloads saturates at 15
      apply(mk(1, 1, 0, 0, 2, 1,  0, 2'b01, 0, 0, 1), 1000);
      for (int k = 1; k <= 50; k++)
         apply(mk(1, 0, 0, 0, 0, 0, 3'(k % 3), 2'b01, logic'(k % 3 == 0),
                  4'((k / 3 > 15) ? 15 : k / 3), 1), 1000 + k);
      // stop aborts the periodic run; cnt holds (50 % 3 = 2)
      apply(mk(1, 0, 1, 0, 0, 0,  2, 2'b00, 0, 0, 0), 1051);
      // a fresh run clears reloads
      apply(mk(1, 1, 0, 0, 1, 1,  0, 2'b01, 0, 0, 1), 1052);
      apply(mk(1, 0, 0, 0, 0, 0,  1, 2'b01, 0, 0, 1), 1053);
      apply(mk(1, 0, 0, 0, 0, 0,  0, 2'b01, 1, 1, 1), 1054);

      if (sb.size() != 0) begin
         n_chk++; n_err++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port res  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to begin a count run; honoured only in IDLE.
REQ-005 SHALL have port stop  input  1  abort request for the current run.
REQ-006 SHALL have port pause  input  1  level; holds the count while high.
REQ-007 SHALL have port limit  input  WIDTH  terminal count, sampled on the accepted start.
REQ-008 SHALL have port auto_reload  input  1  run mode, sampled on the accepted start; 1 = periodic, 0 = one-shot.
REQ-009 SHALL have port cnt  output  WIDTH  current count value (registered).
REQ-010 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-011 SHALL have port done  output  1  one-cycle terminal-count pulse (registered).
REQ-012 SHALL have port reloads  output  4  number of auto-reload wraps in the current run, saturating at 15.
REQ-013 SHALL have port state  output  2  FSM encoding: IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-014 SHALL capture limit into lim_q and auto_reload into auto_q on the edge where start=1 in IDLE.
- On that same edge: cnt<=0, reloads<=0, state<=RUN.
REQ-015 SHALL ignore start in RUN, HOLD and DONE; lim_q and auto_q stay unchanged.
REQ-016 SHALL apply RUN/HOLD priority per edge: stop > pause > count.
REQ-017 In RUN or HOLD with stop=1, SHALL go to IDLE.
- cnt holds its value; done stays 0.
REQ-018 In RUN with stop=0 and pause=1, SHALL go to HOLD; cnt holds.
REQ-019 In HOLD with stop=0 and pause=0, SHALL return to RUN; cnt does not change on that edge.
REQ-020 In RUN with stop=0, pause=0 and cnt!=lim_q, SHALL increment cnt by 1.
REQ-021 In RUN with stop=0, pause=0, cnt==lim_q and auto_q=0, SHALL go to DONE.
- done<=1; cnt holds lim_q.
REQ-022 In RUN with stop=0, pause=0, cnt==lim_q and auto_q=1, SHALL stay in RUN.
- cnt<=0; done<=1; reloads<=reloads+1, saturating at 15.
REQ-023 SHALL go from DONE to IDLE on the next edge unconditionally.
- done<=0; cnt holds.
REQ-024 SHALL drive done high for exactly one cycle per terminal event and low at all other times.
REQ-025 SHALL handle limit=0: the first unpaused RUN edge after start raises done.
REQ-026 SHALL handle limit=2^WIDTH-1 with no overflow of cnt: terminal is detected at all-ones before any wrap.
REQ-027 SHALL give one-shot latency of L+1 unpaused edges from the start edge to the edge that sets done (limit=L).
- Each paused edge adds one.

Reset
REQ-028 On an edge with res=0, SHALL set state=IDLE, cnt=0, done=0, reloads=0, lim_q=0, auto_q=0.
- This overrides all other inputs, including in the middle of a run.
REQ-029 SHALL ignore start on any edge where res=0.

Verification
REQ-030 One-shot: WIDTH=3, limit=5, auto_reload=0, start pulse.
- cnt 0,1,2,3,4,5; done high one cycle with state=11, cnt=5; then state=00, busy=0.
REQ-031 Auto-reload: limit=2, auto_reload=1.
- cnt 0,1,2,0,1,2...; done pulses every 3 cycles; reloads counts 1,2,... and holds 15 after 15 wraps.
REQ-032 Pause/stop: limit=7; pause 2 cycles at cnt=3 -> state=10, cnt stays 3, then resumes to 4.
- stop at cnt=6 -> IDLE, cnt=6, no done.
REQ-033 Boundaries: limit=0 -> done one edge after the RUN entry edge.
- limit=7 -> cnt reaches 7, no wrap.
- start during RUN with a different limit -> ignored.
REQ-034 Reset mid-run: res=0 at cnt=4 in RUN.
- Next cycle state=00, cnt=0, done=0, reloads=0.
- start with res=0 -> stays IDLE.
